// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: bundles the CPU bus, GPU fetch port and VRAM port of the
// VRAM arbiter. The slave modport belongs to the arbiter; the master modport
// is the surrounding system, which drives the CPU/GPU requests and returns
// the VRAM read data. arb_state exposes the arbiter FSM for observation.
interface vram_arbiter_if #(
   parameter int VRAM_AW    = 12,
   parameter int WBUF_DEPTH = 4
);
   localparam int CW = $clog2(WBUF_DEPTH) + 1;

   // CPU bus
   logic [15:0]        cpu_address;
   logic [7:0]         cpu_wdata;
   logic               cpu_rw;
   logic               cpu_valid;
   logic               SELECT_vram;
   logic [7:0]         cpu_rdata;
   logic               cpu_rdy;
   logic [CW-1:0]      wbuf_count;
   // GPU fetch
   logic               gpu_req;
   logic [VRAM_AW-1:0] gpu_addr;
   logic               gpu_ack;
   logic [7:0]         gpu_rdata;
   // VRAM port
   logic [VRAM_AW-1:0] vram_addr;
   logic [7:0]         vram_wdata;
   logic               vram_we;
   logic               vram_re;
   logic [7:0]         vram_rdata;
   // FSM state: 0 IDLE, 1 WR_STALL, 2 RD_WAIT, 3 RD_DATA
   logic [1:0]         arb_state;

   modport slave (
      input  cpu_address, cpu_wdata, cpu_rw, cpu_valid, SELECT_vram,
      input  gpu_req, gpu_addr, vram_rdata,
      output cpu_rdata, cpu_rdy, wbuf_count, gpu_ack, gpu_rdata,
      output vram_addr, vram_wdata, vram_we, vram_re, arb_state
   );

   modport master (
      output cpu_address, cpu_wdata, cpu_rw, cpu_valid, SELECT_vram,
      output gpu_req, gpu_addr, vram_rdata,
      input  cpu_rdata, cpu_rdy, wbuf_count, gpu_ack, gpu_rdata,
      input  vram_addr, vram_wdata, vram_we, vram_re, arb_state
   );
endinterface

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares a single-port synchronous VRAM between the CPU bus and
// the GPU fetch engine. CPU writes are posted into a FIFO and drained in cycles
// the GPU does not use; CPU reads stall the CPU through cpu_rdy.
// Handshake: a CPU cycle is accepted when cpu_valid & SELECT_vram are high
// while cpu_rdy=1; gpu_req is a level held until the one-cycle gpu_ack, which
// arrives the cycle after the grant together with gpu_rdata.
// Optional feature macro: VRAM_ARB_STARVE_GUARD_EN (starvation guard that
// forces a CPU-side VRAM op after STARVE_LIMIT GPU-won cycles).
module vram_arbiter #(
   parameter logic [15:0] VRAM_BASE    = 16'h3700,
   parameter int          VRAM_AW      = 12,
   parameter int          WBUF_DEPTH   = 4,
   parameter int          STARVE_LIMIT = 8
) (
   input logic           clk,
   input logic           rst,
   vram_arbiter_if.slave bus
);
   localparam int PW = $clog2(WBUF_DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WR_STALL = 2'd1,
      RD_WAIT  = 2'd2,
      RD_DATA  = 2'd3
   } state_t;

   state_t state, state_nx;

   logic [VRAM_AW-1:0] fifo_addr [WBUF_DEPTH];
   logic [7:0]         fifo_data [WBUF_DEPTH];
   logic [PW-1:0]      wr_ptr, rd_ptr;
   logic [CW-1:0]      count;
   logic [VRAM_AW-1:0] hold_addr, rd_addr;
   logic [7:0]         hold_data;
   logic [7:0]         cpu_rdata_q;
   logic               gpu_ack_q;

   logic [VRAM_AW-1:0] cpu_off;
   logic               cpu_sel, fifo_empty, fifo_full;
   logic               rd_pend, cpu_side_pend, force_cpu;
   logic               gpu_grant, drain_grant, rd_grant;
   logic               push, hold_cap, rd_cap;
   logic [VRAM_AW-1:0] push_addr;
   logic [7:0]         push_data;

   assign cpu_off    = VRAM_AW'(bus.cpu_address - VRAM_BASE);
   assign cpu_sel    = bus.cpu_valid && bus.SELECT_vram;
   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == CW'(WBUF_DEPTH));

   // A CPU read only competes once every posted write ahead of it has landed.
   assign rd_pend       = (state == RD_WAIT) && fifo_empty;
   assign cpu_side_pend = !fifo_empty || rd_pend;

`ifdef VRAM_ARB_STARVE_GUARD_EN
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   logic [SW-1:0] starve_cnt;

   assign force_cpu = cpu_side_pend && (starve_cnt == SW'(STARVE_LIMIT));

   // Count GPU-won cycles that kept a CPU-side op waiting; clear on CPU grant.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) starve_cnt <= '0;
      else if (drain_grant || rd_grant) starve_cnt <= '0;
      else if (gpu_grant && cpu_side_pend) starve_cnt <= starve_cnt + SW'(1);
   end
`else
   logic unused_limit;
   assign unused_limit = |32'(STARVE_LIMIT);
   assign force_cpu    = 1'b0;
`endif

   // Grant order: GPU read, then FIFO drain, then CPU read.
   assign gpu_grant   = bus.gpu_req && !force_cpu;
   assign drain_grant = !gpu_grant && !fifo_empty;
   assign rd_grant    = !gpu_grant && rd_pend;

   // Next state, FIFO push request and capture strobes.
   always_comb begin
      state_nx  = state;
      push      = 1'b0;
      push_addr = cpu_off;
      push_data = bus.cpu_wdata;
      hold_cap  = 1'b0;
      rd_cap    = 1'b0;
      unique case (state)
         IDLE: begin
            if (cpu_sel && !bus.cpu_rw) begin
               if (!fifo_full) begin
                  push = 1'b1;
               end else begin
                  hold_cap = 1'b1;
                  state_nx = WR_STALL;
               end
            end else if (cpu_sel && bus.cpu_rw) begin
               rd_cap   = 1'b1;
               state_nx = RD_WAIT;
            end
         end
         WR_STALL: begin
            push_addr = hold_addr;
            push_data = hold_data;
            if (!fifo_full) begin
               push     = 1'b1;
               state_nx = IDLE;
            end
         end
         RD_WAIT: if (rd_grant) state_nx = RD_DATA;
         RD_DATA: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // State register, FIFO pointers/occupancy, latched CPU cycle, read/ack regs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         hold_addr   <= '0;
         hold_data   <= '0;
         rd_addr     <= '0;
         cpu_rdata_q <= '0;
         gpu_ack_q   <= 1'b0;
      end else begin
         state     <= state_nx;
         gpu_ack_q <= gpu_grant;
         if (push)        wr_ptr <= wr_ptr + PW'(1);
         if (drain_grant) rd_ptr <= rd_ptr + PW'(1);
         unique case ({push, drain_grant})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (hold_cap) begin
            hold_addr <= cpu_off;
            hold_data <= bus.cpu_wdata;
         end
         if (rd_cap) rd_addr <= cpu_off;
         if (state == RD_DATA) cpu_rdata_q <= bus.vram_rdata;
      end
   end

   // FIFO storage; contents are meaningless once the pointers are reset.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_addr[wr_ptr] <= push_addr;
         fifo_data[wr_ptr] <= push_data;
      end
   end

   assign bus.vram_re    = gpu_grant || rd_grant;
   assign bus.vram_we    = drain_grant;
   assign bus.vram_addr  = gpu_grant   ? bus.gpu_addr :
                           drain_grant ? fifo_addr[rd_ptr] :
                           rd_grant    ? rd_addr : '0;
   assign bus.vram_wdata = fifo_data[rd_ptr];
   assign bus.cpu_rdata  = cpu_rdata_q;
   assign bus.cpu_rdy    = (state == IDLE);
   assign bus.wbuf_count = count;
   assign bus.gpu_ack    = gpu_ack_q;
   assign bus.gpu_rdata  = gpu_ack_q ? bus.vram_rdata : 8'h00;
   assign bus.arb_state  = state;
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: VRAM model, CPU/GPU drivers, write scoreboard, vector table
// and hand sequences for the multi-cycle corners of the VRAM arbiter.
module tb_vram_arbiter;
   localparam int W = 20;
   localparam logic [11:0] GPU_OFF = 12'h800;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;
   logic [W-1:0] exp_q[$];

   vram_arbiter_if #(.VRAM_AW(12), .WBUF_DEPTH(4)) bus ();
   vram_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   // ---------------- VRAM model ----------------
   logic [7:0] mem [4096];
   logic       written [4096];

   function automatic logic [7:0] pat(input logic [11:0] a);
      return a[7:0] ^ 8'h5C ^ {4'h0, a[11:8]};
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4096; i++) written[i] <= 1'b0;
      end else begin
         if (bus.vram_re)
            bus.vram_rdata <= written[bus.vram_addr] ? mem[bus.vram_addr] : pat(bus.vram_addr);
         if (bus.vram_we) begin
            mem[bus.vram_addr]     <= bus.vram_wdata;
            written[bus.vram_addr] <= 1'b1;
         end
      end
   end

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Write scoreboard and GPU data checker.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.vram_we) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_write actual=%0h required=none",
                        {bus.vram_addr, bus.vram_wdata});
            end else begin
               check("drain_write", {bus.vram_addr, bus.vram_wdata}, exp_q.pop_front());
            end
         end
         if (bus.gpu_ack) check("gpu_rdata", bus.gpu_rdata, pat(GPU_OFF));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_rdy(input string name);
      int n = 0;
      while (!bus.cpu_rdy && n < 500) begin
         step();
         n++;
      end
      if (!bus.cpu_rdy) check({name, "_rdy_timeout"}, 32'(bus.cpu_rdy), 32'd1);
   endtask

   task automatic drive(input logic rw, input logic [15:0] addr, input logic [7:0] data,
                        input logic sel);
      bus.cpu_valid   = 1'b1;
      bus.cpu_rw      = rw;
      bus.cpu_address = addr;
      bus.cpu_wdata   = data;
      bus.SELECT_vram = sel;
      if (!rw && sel) exp_q.push_back({12'(addr - 16'h3700), data});
   endtask

   task automatic release_bus();
      bus.cpu_valid   = 1'b0;
      bus.SELECT_vram = 1'b0;
   endtask

   task automatic cpu_write(input logic [15:0] addr, input logic [7:0] data, input logic sel);
      wait_rdy("cpu_write");
      drive(1'b0, addr, data, sel);
      step();
      release_bus();
   endtask

   task automatic cpu_read(input logic [15:0] addr, output logic [7:0] data, output int lat);
      wait_rdy("cpu_read");
      drive(1'b1, addr, 8'h00, 1'b1);
      step();
      release_bus();
      lat = 1;
      while (!bus.cpu_rdy && lat < 500) begin
         step();
         lat++;
      end
      data = bus.cpu_rdata;
   endtask

   task automatic wait_empty(input string name);
      int n = 0;
      while (bus.wbuf_count != 0 && n < 500) begin
         step();
         n++;
      end
      check({name, "_drained"}, 32'(bus.wbuf_count), 32'd0);
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic        rw;
      logic [15:0] addr;
      logic [7:0]  data;
      logic        sel;
      logic [7:0]  exp;
   } vec_t;

   vec_t vecs[11];

   initial begin
      logic [7:0]  rd;
      int          lat;
      int          first_cpu_re;
      logic        ack_at [32];
      logic [11:0] offs [6];
      logic [7:0]  dats [6];

      bus.cpu_address = 16'h0000;
      bus.cpu_wdata   = 8'h00;
      bus.cpu_rw      = 1'b1;
      bus.cpu_valid   = 1'b0;
      bus.SELECT_vram = 1'b0;
      bus.gpu_req     = 1'b0;
      bus.gpu_addr    = GPU_OFF;
      bus.vram_rdata  = 8'h00;

      vecs[0]  = '{1'b0, 16'h3700, 8'h11, 1'b1, 8'h00};
      vecs[1]  = '{1'b0, 16'h3705, 8'hAB, 1'b1, 8'h00};
      vecs[2]  = '{1'b0, 16'h3FFF, 8'h3C, 1'b1, 8'h00};
      vecs[3]  = '{1'b1, 16'h3FFF, 8'h00, 1'b1, 8'h3C};
      vecs[4]  = '{1'b1, 16'h3705, 8'h00, 1'b1, 8'hAB};
      vecs[5]  = '{1'b0, 16'h3710, 8'h77, 1'b0, 8'h00};
      vecs[6]  = '{1'b1, 16'h3710, 8'h00, 1'b1, pat(12'h010)};
      vecs[7]  = '{1'b1, 16'h3700, 8'h00, 1'b1, 8'h11};
      vecs[8]  = '{1'b0, 16'h3800, 8'hC3, 1'b1, 8'h00};
      vecs[9]  = '{1'b1, 16'h3800, 8'h00, 1'b1, 8'hC3};
      vecs[10] = '{1'b1, 16'h3801, 8'h00, 1'b1, pat(12'h101)};

      // 1: reset state
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_cpu_rdy", 32'(bus.cpu_rdy), 32'd1);
      check("rst_wbuf_count", 32'(bus.wbuf_count), 32'd0);
      check("rst_vram_we", 32'(bus.vram_we), 32'd0);
      check("rst_vram_re", 32'(bus.vram_re), 32'd0);
      check("rst_gpu_ack", 32'(bus.gpu_ack), 32'd0);
      check("rst_cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
      check("rst_gpu_rdata", 32'(bus.gpu_rdata), 32'd0);
      step();

      // 2: posted write drains the next cycle
      drive(1'b0, 16'h3705, 8'hAB, 1'b1);
      step();
      release_bus();
      check("t2_vram_we", 32'(bus.vram_we), 32'd1);
      check("t2_vram_addr", 32'(bus.vram_addr), 32'h005);
      check("t2_vram_wdata", 32'(bus.vram_wdata), 32'hAB);
      check("t2_cpu_rdy", 32'(bus.cpu_rdy), 32'd1);
      step();

      // table vectors
      foreach (vecs[i]) begin
         if (vecs[i].rw) begin
            cpu_read(vecs[i].addr, rd, lat);
            check($sformatf("vec%0d_rdata", i), 32'(rd), 32'(vecs[i].exp));
         end else begin
            cpu_write(vecs[i].addr, vecs[i].data, vecs[i].sel);
         end
      end

      // random posted writes then read-back
      for (int k = 0; k < 6; k++) begin
         offs[k] = 12'(12'h200 + k * 16 + $urandom_range(15, 0));
         dats[k] = 8'($urandom_range(255, 0));
         cpu_write(16'h3700 + 16'(offs[k]), dats[k], 1'b1);
      end
      for (int k = 0; k < 6; k++) begin
         cpu_read(16'h3700 + 16'(offs[k]), rd, lat);
         check($sformatf("rand%0d_rdata", k), 32'(rd), 32'(dats[k]));
      end
      wait_empty("rand");

      // minimum read latency with an empty FIFO and no GPU traffic
      cpu_read(16'h3711, rd, lat);
      check("min_read_latency", 32'(lat), 32'd3);
      check("min_read_data", 32'(rd), 32'(pat(12'h011)));

      // 3: GPU holds VRAM, FIFO fills, fifth write stalls
      bus.gpu_req = 1'b1;
      for (int k = 0; k < 5; k++) cpu_write(16'h3720 + 16'(k), 8'hA0 + 8'(k), 1'b1);
      check("t3_wbuf_full", 32'(bus.wbuf_count), 32'd4);
      check("t3_cpu_stalled", 32'(bus.cpu_rdy), 32'd0);
      bus.gpu_req = 1'b0;
      wait_rdy("t3");
      check("t3_rdy_after_pop", 32'(bus.cpu_rdy), 32'd1);
      wait_empty("t3");
      step();
      check("t3_all_drained", 32'(exp_q.size()), 32'd0);

      // 4: write then read the top VRAM byte; drain precedes the read
      wait_rdy("t4");
      drive(1'b0, 16'h3FFF, 8'h5A, 1'b1);
      step();
      check("t4_drain_we", 32'(bus.vram_we), 32'd1);
      check("t4_drain_addr", 32'(bus.vram_addr), 32'h8FF);
      drive(1'b1, 16'h3FFF, 8'h00, 1'b1);
      step();
      release_bus();
      check("t4_read_re", 32'(bus.vram_re), 32'd1);
      check("t4_read_we", 32'(bus.vram_we), 32'd0);
      check("t4_read_addr", 32'(bus.vram_addr), 32'h8FF);
      wait_rdy("t4_read");
      check("t4_rdata", 32'(bus.cpu_rdata), 32'h5A);

      // 5: CPU read against a GPU that never lets go
      step();
      bus.gpu_req = 1'b1;
      drive(1'b1, 16'h3710, 8'h00, 1'b1);
      step();
      release_bus();
      first_cpu_re = 0;
      for (int i = 1; i <= 20; i++) begin
         if (first_cpu_re == 0 && bus.vram_re && bus.vram_addr == 12'h010) first_cpu_re = i;
         ack_at[i] = bus.gpu_ack;
         step();
      end
`ifdef VRAM_ARB_STARVE_GUARD_EN
      check("t5_guard_cpu_re_cycle", 32'(first_cpu_re), 32'd9);
      check("t5_guard_ack_before", 32'(ack_at[9]), 32'd1);
      check("t5_guard_ack_gap", 32'(ack_at[10]), 32'd0);
      check("t5_guard_ack_after", 32'(ack_at[11]), 32'd1);
      check("t5_guard_cpu_rdy", 32'(bus.cpu_rdy), 32'd1);
      bus.gpu_req = 1'b0;
`else
      check("t5_nog_no_cpu_re", 32'(first_cpu_re), 32'd0);
      check("t5_nog_cpu_stalled", 32'(bus.cpu_rdy), 32'd0);
      check("t5_nog_ack_steady", 32'(ack_at[10]), 32'd1);
      bus.gpu_req = 1'b0;
      wait_rdy("t5");
`endif
      check("t5_rdata", 32'(bus.cpu_rdata), 32'(pat(12'h010)));
      step();

      // 6: reset in RD_WAIT with two posted writes outstanding
      bus.gpu_req = 1'b1;
      cpu_write(16'h3730, 8'h31, 1'b1);
      cpu_write(16'h3731, 8'h32, 1'b1);
      wait_rdy("t6");
      drive(1'b1, 16'h3730, 8'h00, 1'b1);
      step();
      release_bus();
      check("t6_in_rd_wait", 32'(bus.arb_state), 32'd2);
      check("t6_fifo_two", 32'(bus.wbuf_count), 32'd2);
      rst = 1'b1;
      #1;
      check("t6_rst_cpu_rdy", 32'(bus.cpu_rdy), 32'd1);
      check("t6_rst_wbuf_count", 32'(bus.wbuf_count), 32'd0);
      check("t6_rst_vram_we", 32'(bus.vram_we), 32'd0);
      exp_q.delete();
      bus.gpu_req = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (6) step();
      check("t6_cpu_rdy_after", 32'(bus.cpu_rdy), 32'd1);
      check("t6_no_pending", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // watchdog
   initial begin
      #500000;
      failures++;
      $display("FAIL watchdog actual=running required=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end
endmodule
